// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Requester-side issue/writeback controller for the SPU ALU. Accepts a
//   decoded instruction over valid/ready, drives the ALU opCode/inA/inB and
//   holds them for the op latency. It then captures the ALU result and emits
//   a one-cycle writeback carrying per-32-bit-word zero flags.
//
// Ports
//   clk_fake     : clock (this block uses posedge; the ALU samples on negedge)
//   reset        : synchronous, active-high reset
//   in_valid     : instruction valid
//   in_ready     : block can accept an instruction (state == IDLE)
//   in_opCode    : instruction opcode
//   in_rt        : destination register
//   in_opA/B     : operands
//   alu_opCode   : ALU opcode, 0 = idle
//   alu_inA/B    : ALU operands
//   alu_dataOut  : ALU result
//   wb_valid     : one-cycle writeback strobe
//   wb_rt        : writeback destination
//   wb_data      : writeback data
//   wb_zero      : wb_zero[i] = (wb_data word i == 0)
//   wb_err       : illegal opcode flag, qualified by wb_valid
module alu_issue_ctrl #(
  parameter int unsigned dataWidth    = 128,
  parameter int unsigned regAddrWidth = 7,
  parameter int unsigned latAdd       = 1,
  parameter int unsigned latMul       = 2
) (
  input  logic                    clk_fake,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5:0]              in_opCode,
  input  logic [regAddrWidth-1:0] in_rt,
  input  logic [dataWidth-1:0]    in_opA,
  input  logic [dataWidth-1:0]    in_opB,
  output logic [5:0]              alu_opCode,
  output logic [dataWidth-1:0]    alu_inA,
  output logic [dataWidth-1:0]    alu_inB,
  input  logic [dataWidth-1:0]    alu_dataOut,
  output logic                    wb_valid,
  output logic [regAddrWidth-1:0] wb_rt,
  output logic [dataWidth-1:0]    wb_data,
  output logic [3:0]              wb_zero,
  output logic                    wb_err
);

  localparam int unsigned LAT_MAX = (latAdd > latMul) ? latAdd : latMul;
  localparam int unsigned CW      = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);
  localparam int unsigned NWORDS  = (dataWidth / 32 < 4) ? dataWidth / 32 : 4;

  typedef enum logic [1:0] {IDLE, EXEC, ERR} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           counter;
  logic [regAddrWidth-1:0] rt_q;

  logic                    accept;
  logic                    legal;
  logic [CW-1:0]           lat_m1;
  logic                    exec_done;
  logic [3:0]              zero_next;

  // Opcode decode and latency selection
  always_comb begin
    legal  = 1'b0;
    lat_m1 = CW'(latAdd - 1);
    unique case (in_opCode)
      6'd4, 6'd6, 6'd28, 6'd30: legal = 1'b1;
      6'd8: begin
        legal  = 1'b1;
        lat_m1 = CW'(latMul - 1);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    accept    = in_valid && (state == IDLE);
    exec_done = (state == EXEC) && (counter == '0);
  end

  // Zero flags come straight from the ALU result being captured
  always_comb begin
    zero_next = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      zero_next[i] = (alu_dataOut[32*i +: 32] == 32'd0);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = legal ? EXEC : ERR;
      EXEC: if (counter == '0) state_next = IDLE;
      ERR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fake) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_fake) begin
    if (reset) begin
      counter    <= '0;
      rt_q       <= '0;
      alu_opCode <= '0;
      alu_inA    <= '0;
      alu_inB    <= '0;
      wb_valid   <= 1'b0;
      wb_rt      <= '0;
      wb_data    <= '0;
      wb_zero    <= '0;
      wb_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        rt_q <= in_rt;
        if (legal) begin
          alu_opCode <= in_opCode;
          alu_inA    <= in_opA;
          alu_inB    <= in_opB;
          counter    <= lat_m1;
        end
      end
      if (state == EXEC && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (exec_done) begin
        wb_valid   <= 1'b1;
        wb_rt      <= rt_q;
        wb_data    <= alu_dataOut;
        wb_zero    <= zero_next;
        wb_err     <= 1'b0;
        alu_opCode <= '0;
      end
      if (state == ERR) begin
        wb_valid <= 1'b1;
        wb_rt    <= rt_q;
        wb_data  <= '0;
        wb_zero  <= '0;
        wb_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned RW = 7;

  logic          clk_fake = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opCode;
  logic [RW-1:0] in_rt;
  logic [DW-1:0] in_opA, in_opB;
  logic [5:0]    alu_opCode;
  logic [DW-1:0] alu_inA, alu_inB, alu_dataOut;
  logic          wb_valid;
  logic [RW-1:0] wb_rt;
  logic [DW-1:0] wb_data;
  logic [3:0]    wb_zero;
  logic          wb_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  alu_issue_ctrl #(.dataWidth(DW), .regAddrWidth(RW), .latAdd(1), .latMul(2)) dut (
    .clk_fake(clk_fake), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opCode(in_opCode),
    .in_rt(in_rt), .in_opA(in_opA), .in_opB(in_opB),
    .alu_opCode(alu_opCode), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_dataOut(alu_dataOut),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
    .wb_zero(wb_zero), .wb_err(wb_err)
  );

  always #5 clk_fake = ~clk_fake;

  // Behavioural ALU; drives a nonzero garbage pattern while idle so that
  // sampling an idle ALU shows up as wrong writeback data.
  always_comb begin
    case (alu_opCode)
      6'd4:    alu_dataOut = alu_inA + alu_inB;
      6'd6:    alu_dataOut = alu_inA - alu_inB;
      6'd8:    alu_dataOut = alu_inA * alu_inB;
      6'd28:   alu_dataOut = alu_inA & alu_inB;
      6'd30:   alu_dataOut = alu_inA | alu_inB;
      default: alu_dataOut = {4{32'hDEAD_BEEF}};
    endcase
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk_fake);
    #1;
  endtask

  typedef struct {
    logic [5:0]    op;
    logic [RW-1:0] rt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_zero;
    logic          exp_err;
    int unsigned   lat;
  } vec_t;

  vec_t vecs[7];

  // Issue one instruction from IDLE and follow it to writeback plus one cycle.
  task automatic run_vec(input vec_t v);
    logic [5:0] exp_op;
    exp_op = v.exp_err ? 6'd0 : v.op;
    in_valid = 1'b1; in_opCode = v.op; in_rt = v.rt; in_opA = v.a; in_opB = v.b;
    tick();
    in_valid = 1'b0;
    check($sformatf("op%0d ready_low", v.op), in_ready, 0);
    check($sformatf("op%0d alu_op", v.op), alu_opCode, exp_op);
    check($sformatf("op%0d no_early_wb", v.op), wb_valid, 0);
    if (!v.exp_err) begin
      check($sformatf("op%0d inA", v.op), alu_inA, v.a);
      check($sformatf("op%0d inB", v.op), alu_inB, v.b);
    end
    for (int unsigned k = 1; k < v.lat; k++) begin
      tick();
      check($sformatf("op%0d hold_op", v.op), alu_opCode, exp_op);
      check($sformatf("op%0d hold_inA", v.op), alu_inA, v.a);
      check($sformatf("op%0d wait_no_wb", v.op), wb_valid, 0);
      check($sformatf("op%0d wait_ready", v.op), in_ready, 0);
    end
    tick();
    check($sformatf("op%0d wb_valid", v.op), wb_valid, 1);
    check($sformatf("op%0d wb_data", v.op), wb_data, v.exp_data);
    check($sformatf("op%0d wb_rt", v.op), wb_rt, v.rt);
    check($sformatf("op%0d wb_zero", v.op), wb_zero, v.exp_zero);
    check($sformatf("op%0d wb_err", v.op), wb_err, v.exp_err);
    check($sformatf("op%0d alu_idle", v.op), alu_opCode, 0);
    check($sformatf("op%0d ready_back", v.op), in_ready, 1);
    tick();
    check($sformatf("op%0d wb_pulse", v.op), wb_valid, 0);
    check($sformatf("op%0d wb_hold", v.op), wb_data, v.exp_data);
  endtask

  initial begin
    logic [DW-1:0] ones;
    ones = '1;
    vecs[0] = '{6'd4,  7'd3,  DW'(5),      DW'(7),      DW'(12),   4'b1110, 1'b0, 1};
    vecs[1] = '{6'd8,  7'd10, DW'(3),      DW'(4),      DW'(12),   4'b1110, 1'b0, 2};
    vecs[2] = '{6'd6,  7'd11, DW'('h1234), DW'('h1234), DW'(0),    4'b1111, 1'b0, 1};
    vecs[3] = '{6'd4,  7'd12, ones,        DW'(1),      DW'(0),    4'b1111, 1'b0, 1};
    vecs[4] = '{6'd5,  7'd9,  DW'(1),      DW'(2),      DW'(0),    4'b0000, 1'b1, 1};
    vecs[5] = '{6'd28, 7'd13, DW'('hF0),   DW'('h3C),   DW'('h30), 4'b1110, 1'b0, 1};
    vecs[6] = '{6'd30, 7'd127, DW'(1) << 32, DW'(1) << 96,
                (DW'(1) << 32) | (DW'(1) << 96), 4'b0101, 1'b0, 1};

    reset = 1'b1; in_valid = 1'b0; in_opCode = '0; in_rt = '0; in_opA = '0; in_opB = '0;
    tick(); tick();
    check("rst in_ready", in_ready, 1);
    check("rst alu_opCode", alu_opCode, 0);
    check("rst alu_inA", alu_inA, 0);
    check("rst alu_inB", alu_inB, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst wb_rt", wb_rt, 0);
    check("rst wb_data", wb_data, 0);
    check("rst wb_zero", wb_zero, 0);
    check("rst wb_err", wb_err, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: second op held on in_valid, accepted on the edge after
    // the first writeback.
    in_valid = 1'b1; in_opCode = 6'd4; in_rt = 7'd20; in_opA = DW'(100); in_opB = DW'(23);
    tick();
    in_opCode = 6'd30; in_rt = 7'd21; in_opA = DW'('h0F); in_opB = DW'('hF0);
    tick();
    check("b2b wb1_valid", wb_valid, 1);
    check("b2b wb1_data", wb_data, DW'(123));
    check("b2b wb1_rt", wb_rt, 20);
    check("b2b ready_with_wb", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b accept2_op", alu_opCode, 30);
    check("b2b gap_no_wb", wb_valid, 0);
    check("b2b gap_ready", in_ready, 0);
    tick();
    check("b2b wb2_valid", wb_valid, 1);
    check("b2b wb2_data", wb_data, DW'('hFF));
    check("b2b wb2_rt", wb_rt, 21);
    tick();
    check("b2b idle_hold_rt", wb_rt, 21);

    // Instruction offered while busy is ignored
    in_valid = 1'b1; in_opCode = 6'd8; in_rt = 7'd40; in_opA = DW'(6); in_opB = DW'(7);
    tick();
    in_opCode = 6'd4; in_rt = 7'd41;
    tick();
    check("busy ignore_op", alu_opCode, 8);
    in_opCode = 6'd8; in_rt = 7'd40;
    tick();
    in_valid = 1'b0;
    check("busy wb_rt", wb_rt, 40);
    check("busy wb_data", wb_data, DW'(42));
    tick(); tick();

    // Reset mid-operation abandons the op
    in_valid = 1'b1; in_opCode = 6'd8; in_rt = 7'd50; in_opA = DW'(9); in_opB = DW'(9);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    check("midrst accepted", alu_opCode, 8);
    tick();
    check("midrst alu_opCode", alu_opCode, 0);
    check("midrst wb_valid", wb_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst wb_data", wb_data, 0);
    check("midrst wb_rt", wb_rt, 0);
    check("midrst alu_inA", alu_inA, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst no_wb", wb_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
